// File: rtl/maze_pkg.sv
// Shared types and constants for the maze memory subsystem: location width,
// destination cell, arbiter state encoding and the per-port access payload.
package maze_pkg;

  localparam int unsigned LOC_W     = 8;
  localparam int unsigned MEM_DEPTH = 1 << LOC_W;
  localparam int unsigned CNT_W     = 4;

  // Location is {row[7:4], col[3:0]}; the bottom-right cell is the goal
  localparam logic [LOC_W-1:0] DEST_LOC = 8'hFF;

  localparam logic OP_RD = 1'b0;
  localparam logic OP_WR = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_S = 2'd1,
    GNT_H = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic             wr;
    logic [LOC_W-1:0] addr;
    logic             wdata;
  } mem_op_t;

endpackage

// File: rtl/maze_mem.sv
// 256x1 maze storage: synchronous write, registered read. Contents are not reset.
module maze_mem
  import maze_pkg::*;
(
  input  logic             clk,
  input  logic             we,
  input  logic [LOC_W-1:0] addr,
  input  logic             wdata,
  output logic             rdata
);

  logic mem [MEM_DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/maze_mem_arbiter.sv
// Single-port arbiter between the maze solver and the host for maze_mem.
// Define MAZE_ARB_RR_EN for round-robin ties instead of solver priority + starvation guard.
module maze_mem_arbiter
  import maze_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_req,
  input  logic             s_wr,
  input  logic [LOC_W-1:0] s_addr,
  input  logic             s_wdata,
  output logic             s_gnt,
  output logic             s_rvalid,
  output logic             s_rdata,
  input  logic             h_req,
  input  logic             h_wr,
  input  logic [LOC_W-1:0] h_addr,
  input  logic             h_wdata,
  output logic             h_gnt,
  output logic             h_rvalid,
  output logic             h_rdata,
  output logic             busy
);

  arb_state_t state;
  arb_state_t state_nxt;

`ifdef MAZE_ARB_RR_EN
  // Last-grant flag resets to host so the solver wins the first tie
  logic last_h;
  logic last_h_nxt;

  always_comb begin
    state_nxt  = IDLE;
    last_h_nxt = last_h;
    case ({s_req, h_req})
      2'b10:   state_nxt = GNT_S;
      2'b01:   state_nxt = GNT_H;
      2'b11:   state_nxt = last_h ? GNT_S : GNT_H;
      default: state_nxt = IDLE;
    endcase
    if (state_nxt != IDLE) begin
      last_h_nxt = (state_nxt == GNT_H);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_h <= 1'b1;
    end else begin
      last_h <= last_h_nxt;
    end
  end
`else
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  // Counts solver grants handed out while the host is kept waiting
  logic [CNT_W-1:0] starve_cnt;
  logic [CNT_W-1:0] starve_cnt_nxt;

  always_comb begin
    state_nxt      = IDLE;
    starve_cnt_nxt = starve_cnt;
    case ({s_req, h_req})
      2'b10:   state_nxt = GNT_S;
      2'b01:   state_nxt = GNT_H;
      2'b11:   state_nxt = (starve_cnt == STARVE_LIM) ? GNT_H : GNT_S;
      default: state_nxt = IDLE;
    endcase
    if (!h_req || (state_nxt == GNT_H)) begin
      starve_cnt_nxt = '0;
    end else if ((state_nxt == GNT_S) && (starve_cnt != STARVE_LIM)) begin
      starve_cnt_nxt = starve_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else begin
      starve_cnt <= starve_cnt_nxt;
    end
  end
`endif

  // State register; grant and busy flops mirror the next state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      s_gnt <= 1'b0;
      h_gnt <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      s_gnt <= (state_nxt == GNT_S);
      h_gnt <= (state_nxt == GNT_H);
      busy  <= (state_nxt != IDLE);
    end
  end

  mem_op_t s_op;
  mem_op_t h_op;
  mem_op_t acc_op;
  logic    mem_we;
  logic    mem_rdata;

  assign s_op   = '{wr: s_wr, addr: s_addr, wdata: s_wdata};
  assign h_op   = '{wr: h_wr, addr: h_addr, wdata: h_wdata};
  assign acc_op = (state == GNT_H) ? h_op : s_op;
  assign mem_we = (state != IDLE) && (acc_op.wr == OP_WR);

  maze_mem u_mem (
    .clk   (clk),
    .we    (mem_we),
    .addr  (acc_op.addr),
    .wdata (acc_op.wdata),
    .rdata (mem_rdata)
  );

  // Read strobes and per-port held copies of the last read value
  logic s_hold;
  logic h_hold;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_rvalid <= 1'b0;
      h_rvalid <= 1'b0;
      s_hold   <= 1'b0;
      h_hold   <= 1'b0;
    end else begin
      s_rvalid <= (state == GNT_S) && (s_wr == OP_RD);
      h_rvalid <= (state == GNT_H) && (h_wr == OP_RD);
      if (s_rvalid) begin
        s_hold <= mem_rdata;
      end
      if (h_rvalid) begin
        h_hold <= mem_rdata;
      end
    end
  end

  // The array's read register feeds the port directly in the valid cycle
  assign s_rdata = s_rvalid ? mem_rdata : s_hold;
  assign h_rdata = h_rvalid ? mem_rdata : h_hold;

endmodule

// File: tb/tb_maze_mem_arbiter.sv
// Self-checking bench for maze_mem_arbiter: grant-pattern table, directed
// corner sequences, and randomized traffic against a cycle-level reference model.
`timescale 1ns/1ps
module tb_maze_mem_arbiter;
  import maze_pkg::*;

  localparam int unsigned STARVE_MAX = 4;
  localparam int M_N = 0;
  localparam int M_S = 1;
  localparam int M_H = 2;

  logic             clk;
  logic             rst;
  logic             s_req, s_wr, s_wdata, s_gnt, s_rvalid, s_rdata;
  logic             h_req, h_wr, h_wdata, h_gnt, h_rvalid, h_rdata;
  logic [LOC_W-1:0] s_addr, h_addr;
  logic             busy;

  int   errors = 0;
  int   checks = 0;
  logic sb_on  = 1'b0;

  maze_mem_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
    .clk      (clk),
    .rst      (rst),
    .s_req    (s_req),
    .s_wr     (s_wr),
    .s_addr   (s_addr),
    .s_wdata  (s_wdata),
    .s_gnt    (s_gnt),
    .s_rvalid (s_rvalid),
    .s_rdata  (s_rdata),
    .h_req    (h_req),
    .h_wr     (h_wr),
    .h_addr   (h_addr),
    .h_wdata  (h_wdata),
    .h_gnt    (h_gnt),
    .h_rvalid (h_rvalid),
    .h_rdata  (h_rdata),
    .busy     (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%b exp=%b", name, $time, got, exp);
    end
  endtask

  // Reference model: who owns the current cycle, how many solver grants the
  // waiting host has been passed over for, plus a plain memory array
  logic m_mem [MEM_DEPTH];
  int   m_g;
  int   m_wait;
  logic m_last_s;
  logic m_srv, m_hrv, m_srd, m_hrd;

  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      m_g = M_N; m_wait = 0; m_last_s = 1'b0;
      m_srv = 1'b0; m_hrv = 1'b0; m_srd = 1'b0; m_hrd = 1'b0;
    end else begin
      m_srv = 1'b0;
      m_hrv = 1'b0;
      if (m_g == M_S) begin
        if (s_wr) m_mem[s_addr] = s_wdata;
        else begin m_srv = 1'b1; m_srd = m_mem[s_addr]; end
      end else if (m_g == M_H) begin
        if (h_wr) m_mem[h_addr] = h_wdata;
        else begin m_hrv = 1'b1; m_hrd = m_mem[h_addr]; end
      end
      if (s_req && h_req) begin
`ifdef MAZE_ARB_RR_EN
        m_g = m_last_s ? M_H : M_S;
`else
        m_g = (m_wait >= int'(STARVE_MAX)) ? M_H : M_S;
`endif
      end else if (s_req) m_g = M_S;
      else if (h_req)     m_g = M_H;
      else                m_g = M_N;
      if (m_g == M_H || !h_req) m_wait = 0;
      else if (m_g == M_S)      m_wait++;
      if (m_g != M_N) m_last_s = (m_g == M_S);
    end
  end

  // Scoreboard: every output, every cycle, away from the active edge
  initial forever begin
    @(negedge clk);
    if (sb_on) begin
      chk("sb_s_gnt",    s_gnt,    m_g == M_S);
      chk("sb_h_gnt",    h_gnt,    m_g == M_H);
      chk("sb_busy",     busy,     m_g != M_N);
      chk("sb_s_rvalid", s_rvalid, m_srv);
      chk("sb_h_rvalid", h_rvalid, m_hrv);
      chk("sb_s_rdata",  s_rdata,  m_srd);
      chk("sb_h_rdata",  h_rdata,  m_hrd);
    end
  end

  // Grant-pattern table
  typedef struct {
    logic s_req;
    logic h_req;
    logic exp_s;
    logic exp_h;
  } vec_t;

  vec_t tbl [64];
  int   ntbl = 0;

  task automatic add_run(input logic s, input logic h, input string pat);
    for (int i = 0; i < pat.len(); i++) begin
      tbl[ntbl].s_req = s;
      tbl[ntbl].h_req = h;
      tbl[ntbl].exp_s = (pat[i] == "S");
      tbl[ntbl].exp_h = (pat[i] == "H");
      ntbl++;
    end
  endtask

  // Single access from one port; called and returns on a negedge
  task automatic port_op(input string name, input logic host, input logic wr,
                         input logic [LOC_W-1:0] addr, input logic wdata,
                         input logic check_rd, input logic exp_rd);
    int   n;
    logic g;
    if (host) begin h_req = 1'b1; h_wr = wr; h_addr = addr; h_wdata = wdata; end
    else      begin s_req = 1'b1; s_wr = wr; s_addr = addr; s_wdata = wdata; end
    n = 0;
    g = 1'b0;
    while (!g && n < 20) begin
      @(negedge clk);
      g = host ? h_gnt : s_gnt;
      n++;
    end
    chk({name, "_grant"}, g, 1'b1);
    if (check_rd) chk({name, "_latency"}, n == 1, 1'b1);
    if (host) h_req = 1'b0; else s_req = 1'b0;
    @(negedge clk);
    if (check_rd) begin
      chk({name, "_rvalid"}, host ? h_rvalid : s_rvalid, 1'b1);
      chk({name, "_rdata"},  host ? h_rdata  : s_rdata,  exp_rd);
    end
  endtask

  function automatic logic [LOC_W-1:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return DEST_LOC;
    return LOC_W'($urandom_range(0, 15));
  endfunction

  task automatic random_phase(input int ncyc);
    logic s_prev, h_prev;
    s_prev = 1'b0;
    h_prev = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk);
      #1;
      if (s_gnt) s_req = 1'($urandom_range(0, 1));
      else if (s_prev || !s_req) begin
        s_req   = ($urandom_range(0, 3) != 0);
        s_wr    = 1'($urandom_range(0, 1));
        s_addr  = rand_addr();
        s_wdata = 1'($urandom_range(0, 1));
      end
      s_prev = s_gnt;
      if (h_gnt) h_req = 1'($urandom_range(0, 1));
      else if (h_prev || !h_req) begin
        h_req   = 1'($urandom_range(0, 1));
        h_wr    = 1'($urandom_range(0, 1));
        h_addr  = rand_addr();
        h_wdata = 1'($urandom_range(0, 1));
      end
      h_prev = h_gnt;
    end
  endtask

  initial begin
`ifdef MAZE_ARB_RR_EN
    add_run(1'b1, 1'b1, "SHSHSHSHSH");
    add_run(1'b0, 1'b0, "NN");
    add_run(1'b1, 1'b0, "SSSSSS");
    add_run(1'b1, 1'b1, "HSHSH");
    add_run(1'b0, 1'b1, "HH");
    add_run(1'b0, 1'b0, "N");
`else
    add_run(1'b1, 1'b1, "SSSSHSSSSH");
    add_run(1'b0, 1'b0, "NN");
    add_run(1'b1, 1'b0, "SSSSSS");
    add_run(1'b1, 1'b1, "SSSSH");
    add_run(1'b0, 1'b1, "HH");
    add_run(1'b0, 1'b0, "N");
`endif

    s_req = 1'b0; s_wr = 1'b0; s_addr = '0; s_wdata = 1'b0;
    h_req = 1'b0; h_wr = 1'b0; h_addr = '0; h_wdata = 1'b0;
    rst = 1'b1;
    #2 rst = 1'b0;
    sb_on = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);

    chk("rst_s_gnt", s_gnt, 1'b0);
    chk("rst_h_gnt", h_gnt, 1'b0);
    chk("rst_busy",  busy,  1'b0);
    chk("rst_s_rdata", s_rdata, 1'b0);
    chk("rst_h_rdata", h_rdata, 1'b0);

    // Fill the whole array from the host so every later read is defined
    for (int a = 0; a < int'(MEM_DEPTH); a++) begin
      port_op("init", 1'b1, OP_WR, LOC_W'(a), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    end

    // Host write then solver read of the same cell
    port_op("h_wr12", 1'b1, OP_WR, 8'h12, 1'b1, 1'b0, 1'b0);
    port_op("s_rd12", 1'b0, OP_RD, 8'h12, 1'b0, 1'b1, 1'b1);

    // Back-to-back host write 0 then read of the destination cell
    port_op("h_wrff", 1'b1, OP_WR, DEST_LOC, 1'b1, 1'b0, 1'b0);
    h_req = 1'b1; h_wr = OP_WR; h_addr = DEST_LOC; h_wdata = 1'b0;
    @(negedge clk);
    chk("b2b_gnt1", h_gnt, 1'b1);
    @(posedge clk);
    #1;
    h_wr = OP_RD;
    h_req = 1'b0;
    chk("b2b_gnt2", h_gnt, 1'b1);
    @(negedge clk);
    chk("b2b_no_rvalid", h_rvalid, 1'b0);
    @(negedge clk);
    chk("b2b_rvalid", h_rvalid, 1'b1);
    chk("b2b_rdata",  h_rdata,  1'b0);

    // Reset in the middle of a host write grant
    port_op("h_rd12", 1'b1, OP_RD, 8'h12, 1'b0, 1'b1, 1'b1);
    port_op("h_wr34", 1'b1, OP_WR, 8'h34, 1'b0, 1'b0, 1'b0);
    h_req = 1'b1; h_wr = OP_WR; h_addr = 8'h34; h_wdata = 1'b1;
    @(negedge clk);
    chk("mid_gnt", h_gnt, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_s_gnt",    s_gnt,    1'b0);
    chk("mid_rst_h_gnt",    h_gnt,    1'b0);
    chk("mid_rst_busy",     busy,     1'b0);
    chk("mid_rst_s_rvalid", s_rvalid, 1'b0);
    chk("mid_rst_h_rvalid", h_rvalid, 1'b0);
    chk("mid_rst_s_rdata",  s_rdata,  1'b0);
    chk("mid_rst_h_rdata",  h_rdata,  1'b0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    chk("rst_regrant", h_gnt, 1'b1);
    h_req = 1'b0;
    @(negedge clk);
    port_op("h_rd34", 1'b1, OP_RD, 8'h34, 1'b0, 1'b1, 1'b1);

    // Table-driven grant patterns (reads only)
    s_wr = OP_RD; s_addr = 8'h12;
    h_wr = OP_RD; h_addr = DEST_LOC;
    for (int i = 0; i < ntbl; i++) begin
      s_req = tbl[i].s_req;
      h_req = tbl[i].h_req;
      @(negedge clk);
      chk($sformatf("tbl%0d_s_gnt", i), s_gnt, tbl[i].exp_s);
      chk($sformatf("tbl%0d_h_gnt", i), h_gnt, tbl[i].exp_h);
    end

    random_phase(3000);
    @(posedge clk);
    #1;
    s_req = 1'b0;
    h_req = 1'b0;
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog t=%0t got=running exp=finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
